// File: rtl/enc_pkg.sv
// ============================================================================
// Module      : enc_pkg
// Description : Shared constants and helpers for the 8-to-3 handshake encoder.
//               Optional feature macro used by the encoder: ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = 3;

    // One-hot mask with only bit idx set
    function automatic logic [N_IN-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_IN-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe8to3_core.sv
// ============================================================================
// Module      : pe8to3_core
// Description : Combinational priority search over an 8-bit vector.
//               ROUND_ROBIN_EN defined   : upward search from start, 7 wraps to 0.
//               ROUND_ROBIN_EN undefined : downward search from start-1, so with
//                                          start=0 the highest set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe8to3_core
    import enc_pkg::*;
(
    input  logic [N_IN-1:0]  vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk all 8 positions in priority order; the first set bit is taken
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int i = 0; i < N_IN; i++) begin
`ifdef ROUND_ROBIN_EN
            w_cand = start + IDX_W'(i);
`else
            w_cand = start - IDX_W'(1) - IDX_W'(i);
`endif
            if (!any && vec[w_cand]) begin
                idx = w_cand;
                any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/priority_encoder8to3_hs.sv
// ============================================================================
// Module      : priority_encoder8to3_hs
// Description : Latches 8-bit event requests into a pending mask and emits each
//               as a 3-bit index over a valid/ready handshake, one per cycle.
//               Build option ROUND_ROBIN_EN selects rotating priority; the
//               default build uses fixed priority (bit 7 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder8to3_hs
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] code,
    output logic [N_IN-1:0]  pending,
    output logic             dup
);

    logic [N_IN-1:0]  pending_q, pending_d;
    logic             out_valid_q;
    logic [IDX_W-1:0] code_q;
    logic             dup_q, dup_d;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic             w_load;
    logic [N_IN-1:0]  w_clr;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;

    // Rotate the search start to just past the last issued index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (w_load) begin
            rr_ptr_q <= w_sel + IDX_W'(1);
        end
    end

    assign w_start = rr_ptr_q;
`else
    assign w_start = '0;
`endif

    pe8to3_core u_core (
        .vec   (pending_q),
        .start (w_start),
        .idx   (w_sel),
        .any   (w_any)
    );

    // Refill the output register whenever it is empty or draining this cycle
    assign w_load = w_any && (!out_valid_q || out_ready);
    assign w_clr  = w_load ? onehot8(w_sel) : '0;

    // Issued bit leaves pending; new requests are OR-ed in and win over the clear
    always_comb begin
        pending_d = (pending_q & ~w_clr) | req;
        dup_d     = |(req & pending_q & ~w_clr);
    end

    // Pending mask and duplicate-arrival flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            dup_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dup_q     <= dup_d;
        end
    end

    // Output register: load on refill, drop valid on accept without refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
        end else if (w_load) begin
            out_valid_q <= 1'b1;
            code_q      <= w_sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign code      = code_q;
    assign pending   = pending_q;
    assign dup       = dup_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder8to3_hs.sv
// ============================================================================
// Module      : tb_priority_encoder8to3_hs
// Description : Directed self-checking bench for priority_encoder8to3_hs.
//               Expectations follow the build's ROUND_ROBIN_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder8to3_hs;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] code;
    logic [7:0] pending;
    logic       dup;

    int n_checks = 0;
    int n_errors = 0;

    priority_encoder8to3_hs dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .pending   (pending),
        .dup       (dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] dec;
        rst       = 1'b1;
        req       = 8'h00;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state, and nothing emitted on the first cycle after deassert
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_pending", 32'(pending),   32'h00);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // Async reset mid-stream
        out_ready = 1'b0;
        req = 8'hA5; tick();
        req = 8'h00; tick();
        req = 8'hA5; tick();
        req = 8'h00;
        chk("pre_rst_pending", 32'(pending),   32'hA5);
        chk("pre_rst_valid",   32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_pending", 32'(pending),   32'h00);
        chk("async_valid",   32'(out_valid), 32'd0);
        chk("async_code",    32'(code),      32'd0);
        chk("async_dup",     32'(dup),       32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // Single request, two-cycle latency
        req = 8'b0000_0100; tick();
        req = 8'h00;
        chk("lat_n1_valid",   32'(out_valid), 32'd0);
        chk("lat_n1_pending", 32'(pending),   32'h04);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_code",  32'(code),      32'd2);
        tick();
        chk("lat_idle_valid", 32'(out_valid), 32'd0);

        // All eight requests drain back-to-back
        do_reset();
        req = 8'hFF; tick();
        req = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("ff_valid", 32'(out_valid), 32'd1);
`ifdef ROUND_ROBIN_EN
            chk("ff_code", 32'(code), 32'(k));
`else
            chk("ff_code", 32'(code), 32'(7 - k));
`endif
        end
        tick();
        chk("ff_done_valid", 32'(out_valid), 32'd0);

`ifndef ROUND_ROBIN_EN
        // Stall, hold, duplicate detection, then drain
        do_reset();
        out_ready = 1'b0;
        req = 8'h09; tick();
        req = 8'h00; tick();
        chk("stall_code",    32'(code),      32'd3);
        chk("stall_valid",   32'(out_valid), 32'd1);
        chk("stall_pending", 32'(pending),   32'h01);
        tick();
        chk("hold_code",  32'(code),      32'd3);
        chk("hold_valid", 32'(out_valid), 32'd1);
        req = 8'h01; tick();
        req = 8'h00;
        chk("dup_pulse", 32'(dup), 32'd1);
        tick();
        chk("dup_clear", 32'(dup), 32'd0);
        chk("pre_drain_code", 32'(code), 32'd3);
        out_ready = 1'b1; tick();
        chk("drain_code",  32'(code),      32'd0);
        chk("drain_valid", 32'(out_valid), 32'd1);
        tick();
        chk("drain_idle", 32'(out_valid), 32'd0);
`endif

        // Held request on bits 0 and 7
        do_reset();
        req = 8'h81; tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold81_valid", 32'(out_valid), 32'd1);
`ifdef ROUND_ROBIN_EN
            chk("hold81_code", 32'(code), (k % 2 == 0) ? 32'd0 : 32'd7);
`else
            chk("hold81_code", 32'(code), 32'd7);
`endif
        end
        req = 8'h00;

        // Every single-bit request round-trips through a 3-to-8 decoder
        do_reset();
        for (int a = 0; a < 8; a++) begin
            req = 8'h01 << a; tick();
            req = 8'h00; tick();
            dec = 8'h01 << code;
            chk("dec_valid", 32'(out_valid), 32'd1);
            chk("dec_y",     32'(dec),       32'(8'h01 << a));
            tick();
            chk("dec_idle", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
